// File: rtl/pipe_stall_ctrl_if.sv
// Hazard/stall handshake bundle between the hazard detection unit (master) and the
// pipeline stall controller (slave).
interface pipe_stall_ctrl_if;

  logic        stall_req;
  logic        hlt_req;
  logic        branch_taken;
  logic        pc_wen;
  logic        if_id_wen;
  logic        if_id_flush;
  logic        id_ex_bubble;
  logic        halted;
  logic [15:0] stall_cycles;

  // Hazard unit side: raises requests, observes stage enables.
  modport master (
    output stall_req,
    output hlt_req,
    output branch_taken,
    input  pc_wen,
    input  if_id_wen,
    input  if_id_flush,
    input  id_ex_bubble,
    input  halted,
    input  stall_cycles
  );

  // Controller side: consumes requests, drives stage enables.
  modport slave (
    input  stall_req,
    input  hlt_req,
    input  branch_taken,
    output pc_wen,
    output if_id_wen,
    output if_id_flush,
    output id_ex_bubble,
    output halted,
    output stall_cycles
  );

endinterface

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall controller: turns hazard/halt requests and branch resolution into
// PC / IF-ID / ID-EX enables for the 5-stage pipeline, sequences the HLT drain and
// counts stalled cycles.
module pipe_stall_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  pipe_stall_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StFlush  = 2'd1,
    StDrain  = 2'd2,
    StHalted = 2'd3
  } state_e;

  // The branch cycle is the first flush cycle, so FLUSH holds for FLUSH_CYCLES-1 more.
  localparam logic [CNT_W-1:0] LP_FLUSH_LOAD =
      CNT_W'((FLUSH_CYCLES > 1) ? (FLUSH_CYCLES - 2) : 0);
  // Likewise the cycle HLT is first seen is the first drain cycle; with DRAIN_CYCLES==1
  // the controller goes straight to HALTED on the following edge.
  localparam logic [CNT_W-1:0] LP_DRAIN_LOAD =
      CNT_W'((DRAIN_CYCLES > 1) ? (DRAIN_CYCLES - 2) : 0);

  state_e           r_state;
  state_e           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [15:0]      r_stall_cycles;

  logic w_pc_wen;
  logic w_if_id_wen;
  logic w_if_id_flush;
  logic w_id_ex_bubble;
  logic w_halted;
  logic w_count_en;

  // Next-state and same-cycle stage enables from state, inputs and reset.
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_pc_wen       = 1'b1;
    w_if_id_wen    = 1'b1;
    w_if_id_flush  = 1'b0;
    w_id_ex_bubble = 1'b0;
    w_halted       = 1'b0;

    if (i_rst) begin
      w_pc_wen       = 1'b0;
      w_if_id_wen    = 1'b0;
      w_if_id_flush  = 1'b1;
      w_id_ex_bubble = 1'b1;
      w_state_next   = StRun;
      w_cnt_next     = '0;
    end else if ((r_state != StHalted) && bus.branch_taken) begin
      // Taken branch wins everywhere short of HALTED: PC loads the target, the wrong-path
      // instruction in IF/ID is squashed. A branch during DRAIN means the HLT was wrong path.
      w_if_id_flush  = 1'b1;
      w_id_ex_bubble = 1'b1;
      w_state_next   = (FLUSH_CYCLES == 1) ? StRun : StFlush;
      w_cnt_next     = LP_FLUSH_LOAD;
    end else begin
      case (r_state)
        StRun: begin
          if (bus.hlt_req) begin
            w_pc_wen       = 1'b0;
            w_if_id_wen    = 1'b0;
            w_id_ex_bubble = 1'b1;
            w_state_next   = (DRAIN_CYCLES == 1) ? StHalted : StDrain;
            w_cnt_next     = LP_DRAIN_LOAD;
          end else if (bus.stall_req) begin
            w_pc_wen       = 1'b0;
            w_if_id_wen    = 1'b0;
            w_id_ex_bubble = 1'b1;
          end
        end
        StFlush: begin
          // Requests seen here come from the wrong path and are ignored.
          w_if_id_flush  = 1'b1;
          w_id_ex_bubble = 1'b1;
          if (r_cnt == '0) begin
            w_state_next = StRun;
          end else begin
            w_cnt_next = r_cnt - CNT_W'(1);
          end
        end
        StDrain: begin
          w_pc_wen       = 1'b0;
          w_if_id_wen    = 1'b0;
          w_id_ex_bubble = 1'b1;
          if (r_cnt == '0) begin
            w_state_next = StHalted;
          end else begin
            w_cnt_next = r_cnt - CNT_W'(1);
          end
        end
        StHalted: begin
          w_pc_wen       = 1'b0;
          w_if_id_wen    = 1'b0;
          w_id_ex_bubble = 1'b1;
          w_halted       = 1'b1;
        end
        default: begin
          w_state_next = StRun;
          w_cnt_next   = '0;
        end
      endcase
    end
  end

  // Stalled cycles count only while not halted and not in reset; flush cycles keep pc_wen=1.
  assign w_count_en = !w_pc_wen && (r_state != StHalted) && !i_rst;

  // State and drain/flush counter register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StRun;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Saturating stall performance counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_cycles <= '0;
    end else if (w_count_en && (r_stall_cycles != 16'hFFFF)) begin
      r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  assign bus.pc_wen       = w_pc_wen;
  assign bus.if_id_wen    = w_if_id_wen;
  assign bus.if_id_flush  = w_if_id_flush;
  assign bus.id_ex_bubble = w_id_ex_bubble;
  assign bus.halted       = w_halted;
  assign bus.stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: two instances (DRAIN=3/FLUSH=1 and DRAIN=1/FLUSH=3) driven
// by directed and random stimulus; expected outputs come from a behavioural model and are
// queued per cycle, then popped and compared by an independent monitor.
module tb_pipe_stall_ctrl;

  localparam int DA = 3;
  localparam int FA = 1;
  localparam int DB = 1;
  localparam int FB = 3;

  typedef struct packed {
    bit rst;
    bit stall;
    bit hlt;
    bit br;
  } stim_t;

  typedef struct packed {
    logic        pc_wen;
    logic        if_id_wen;
    logic        flush;
    logic        bubble;
    logic        halted;
    logic [15:0] cnt;
  } out_t;

  typedef struct {
    out_t o;
    bit   known;
    int   cyc;
  } item_t;

  // Model state: pending wrong-path flush cycles, pending drain cycles, halt flag, count.
  typedef struct {
    bit          known;
    bit          halted;
    bit          draining;
    int          flush_left;
    int          drain_left;
    int unsigned count;
  } mdl_t;

  logic clk;
  logic rst_a;
  logic rst_b;

  pipe_stall_ctrl_if bus_a ();
  pipe_stall_ctrl_if bus_b ();

  pipe_stall_ctrl #(
    .DRAIN_CYCLES(DA),
    .FLUSH_CYCLES(FA),
    .CNT_W       (3)
  ) dut_a (
    .i_clk(clk),
    .i_rst(rst_a),
    .bus  (bus_a.slave)
  );

  pipe_stall_ctrl #(
    .DRAIN_CYCLES(DB),
    .FLUSH_CYCLES(FB),
    .CNT_W       (3)
  ) dut_b (
    .i_clk(clk),
    .i_rst(rst_b),
    .bus  (bus_b.slave)
  );

  stim_t sa;
  stim_t sb;
  mdl_t  ma;
  mdl_t  mb;
  item_t qa[$];
  item_t qb[$];
  int    cyc;
  int    checks;
  int    errors;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model of one cycle: outputs for this cycle and state after the edge.
  task automatic model_step(input mdl_t m, input stim_t s, input int d, input int f,
                            output mdl_t mn, output out_t e);
    bit stalled;
    mn      = m;
    stalled = 1'b0;
    e       = '0;
    e.cnt   = m.count[15:0];
    if (s.rst) begin
      e.flush  = 1'b1;
      e.bubble = 1'b1;
      mn       = '{known: 1'b1, halted: 1'b0, draining: 1'b0, flush_left: 0,
                   drain_left: 0, count: 0};
    end else if (m.halted) begin
      e.bubble = 1'b1;
      e.halted = 1'b1;
    end else if (s.br) begin
      e.pc_wen      = 1'b1;
      e.if_id_wen   = 1'b1;
      e.flush       = 1'b1;
      e.bubble      = 1'b1;
      mn.flush_left = f - 1;
      mn.draining   = 1'b0;
    end else if (m.flush_left > 0) begin
      e.pc_wen      = 1'b1;
      e.if_id_wen   = 1'b1;
      e.flush       = 1'b1;
      e.bubble      = 1'b1;
      mn.flush_left = m.flush_left - 1;
    end else if (m.draining) begin
      stalled       = 1'b1;
      mn.drain_left = m.drain_left - 1;
      if (mn.drain_left == 0) begin
        mn.draining = 1'b0;
        mn.halted   = 1'b1;
      end
    end else if (s.hlt) begin
      stalled = 1'b1;
      if (d == 1) begin
        mn.halted = 1'b1;
      end else begin
        mn.draining   = 1'b1;
        mn.drain_left = d - 1;
      end
    end else if (s.stall) begin
      stalled = 1'b1;
    end else begin
      e.pc_wen    = 1'b1;
      e.if_id_wen = 1'b1;
    end
    if (stalled) begin
      e.bubble = 1'b1;
      if (m.count < 32'd65535) mn.count = m.count + 1;
    end
  endtask

  task automatic step();
    item_t ia;
    item_t ib;
    mdl_t  na;
    mdl_t  nb;
    @(negedge clk);
    rst_a              = sa.rst;
    bus_a.stall_req    = sa.stall;
    bus_a.hlt_req      = sa.hlt;
    bus_a.branch_taken = sa.br;
    rst_b              = sb.rst;
    bus_b.stall_req    = sb.stall;
    bus_b.hlt_req      = sb.hlt;
    bus_b.branch_taken = sb.br;
    model_step(ma, sa, DA, FA, na, ia.o);
    model_step(mb, sb, DB, FB, nb, ib.o);
    ia.known = ma.known;
    ib.known = mb.known;
    ia.cyc   = cyc;
    ib.cyc   = cyc;
    qa.push_back(ia);
    qb.push_back(ib);
    ma  = na;
    mb  = nb;
    cyc = cyc + 1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic compare(input string name, input item_t it, input out_t act);
    logic [20:0] mask;
    mask   = it.known ? 21'h1FFFFF : 21'h1F0000;
    checks = checks + 1;
    if ((act & mask) !== (it.o & mask)) begin
      errors = errors + 1;
      $display("FAIL %s cyc %0d got pc=%b ifw=%b fl=%b bub=%b hlt=%b cnt=%h exp pc=%b ifw=%b fl=%b bub=%b hlt=%b cnt=%h",
               name, it.cyc, act.pc_wen, act.if_id_wen, act.flush, act.bubble, act.halted,
               act.cnt, it.o.pc_wen, it.o.if_id_wen, it.o.flush, it.o.bubble, it.o.halted,
               it.o.cnt);
    end
  endtask

  // Monitor: samples both DUTs mid-cycle and checks against the queued expectations.
  initial begin
    item_t it;
    out_t  act;
    forever begin
      @(negedge clk);
      #2;
      if (qa.size() > 0) begin
        it            = qa.pop_front();
        act.pc_wen    = bus_a.pc_wen;
        act.if_id_wen = bus_a.if_id_wen;
        act.flush     = bus_a.if_id_flush;
        act.bubble    = bus_a.id_ex_bubble;
        act.halted    = bus_a.halted;
        act.cnt       = bus_a.stall_cycles;
        compare("dut_a", it, act);
      end
      if (qb.size() > 0) begin
        it            = qb.pop_front();
        act.pc_wen    = bus_b.pc_wen;
        act.if_id_wen = bus_b.if_id_wen;
        act.flush     = bus_b.if_id_flush;
        act.bubble    = bus_b.id_ex_bubble;
        act.halted    = bus_b.halted;
        act.cnt       = bus_b.stall_cycles;
        compare("dut_b", it, act);
      end
    end
  end

  // Stimulus.
  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    ma     = '{known: 1'b0, halted: 1'b0, draining: 1'b0, flush_left: 0, drain_left: 0,
               count: 0};
    mb     = ma;
    sa     = '0;
    sb     = '0;
    sa.rst = 1'b1;
    sb.rst = 1'b1;
    rst_a  = 1'b1;
    rst_b  = 1'b1;
    bus_a.stall_req = 1'b0; bus_a.hlt_req = 1'b0; bus_a.branch_taken = 1'b0;
    bus_b.stall_req = 1'b0; bus_b.hlt_req = 1'b0; bus_b.branch_taken = 1'b0;

    // Reset then idle.
    run(2);
    sa = '0; sb = '0;
    run(5);
    // Two-cycle load-use stall.
    sa.stall = 1'b1; run(2);
    sa.stall = 1'b0; run(2);
    // HLT held until halted, then inputs toggle while halted.
    sa.hlt = 1'b1; run(5);
    for (int i = 0; i < 8; i++) begin
      sa.stall = 1'($urandom_range(1));
      sa.br    = 1'($urandom_range(1));
      run(1);
    end
    sa = '0; sa.rst = 1'b1; run(1);
    sa = '0; run(2);
    // Branch together with stall and HLT.
    sa = '{rst: 1'b0, stall: 1'b1, hlt: 1'b1, br: 1'b1}; run(1);
    sa = '0; run(3);
    // Branch one cycle into DRAIN aborts the halt.
    sa.hlt = 1'b1; run(1);
    sa.br  = 1'b1; run(1);
    sa = '0; run(4);
    // Three-cycle flush and back-to-back restarts on dut_b.
    sb.br = 1'b1; run(1);
    sb.br = 1'b0; run(4);
    sb.br = 1'b1; run(1);
    sb.br = 1'b0; run(1);
    sb.br = 1'b1; run(1);
    sb.br = 1'b0; run(4);
    // DRAIN_CYCLES==1 halts on the next edge.
    sb.hlt = 1'b1; run(1);
    sb.hlt = 1'b0; run(3);
    sb.rst = 1'b1; run(1);
    sb.rst = 1'b0; run(1);
    // Reset in the middle of a drain.
    sa.hlt = 1'b1; run(2);
    sa = '0; sa.rst = 1'b1; run(1);
    sa = '0; run(3);
    // Random mix on both instances.
    for (int i = 0; i < 600; i++) begin
      sa.rst   = ($urandom_range(63) == 0);
      sa.br    = ($urandom_range(7) == 0);
      sa.hlt   = ($urandom_range(15) == 0);
      sa.stall = ($urandom_range(3) == 0);
      sb.rst   = ($urandom_range(63) == 0);
      sb.br    = ($urandom_range(7) == 0);
      sb.hlt   = ($urandom_range(15) == 0);
      sb.stall = ($urandom_range(3) == 0);
      run(1);
    end
    // Long stall to saturate the counter.
    sa = '0; sb = '0; sa.rst = 1'b1; sb.rst = 1'b1; run(1);
    sa = '0; sb = '0;
    sa.stall = 1'b1; run(65540);
    sa.stall = 1'b0; run(2);
    sa.rst = 1'b1; run(1);
    sa = '0; run(2);

    @(negedge clk);
    #4;
    checks = checks + 1;
    if ((qa.size() != 0) || (qb.size() != 0)) begin
      errors = errors + 1;
      $display("FAIL queue_drain got %0d/%0d pending exp 0/0", qa.size(), qb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
